// File: rtl/warmboot_sequencer_if.sv
// Signal bundle between the bootloader core / board top level and the warm-boot sequencer.
interface warmboot_sequencer_if;
  logic       boot_req;
  logic       pll_lock;
  logic       spi_cs;
  logic       usb_detach;
  logic [1:0] wb_s;
  logic       wb_boot;
  logic       busy;

  modport master (
    output boot_req, pll_lock, spi_cs,
    input  usb_detach, wb_s, wb_boot, busy
  );

  modport slave (
    input  boot_req, pll_lock, spi_cs,
    output usb_detach, wb_s, wb_boot, busy
  );
endinterface

// File: rtl/warmboot_sequencer.sv
// Warm-boot hand-off: wait for SPI flash idle, hold USB in SE0, then fire SB_WARMBOOT.
//
// state   | meaning
// IDLE    | waiting for a boot_req rising edge with PLL locked
// QUIESCE | counting consecutive spi_cs-high cycles; abortable
// DETACH  | USB forced to SE0 for DETACH_CYCLES; committed
// BOOT    | wb_boot asserted for BOOT_CYCLES
// DONE    | wb_boot/usb_detach held until reset (device reconfigures)
module warmboot_sequencer #(
  parameter logic [1:0] IMAGE_SEL       = 2'b01,
  parameter int         SPI_IDLE_CYCLES = 64,
  parameter int         DETACH_CYCLES   = 480000,
  parameter int         BOOT_CYCLES     = 4
) (
  input logic                 clk_48mhz,
  input logic                 resetb,
  warmboot_sequencer_if.slave wb_if
);

  localparam int MAX_AB  = (SPI_IDLE_CYCLES > DETACH_CYCLES) ? SPI_IDLE_CYCLES : DETACH_CYCLES;
  localparam int MAX_CYC = (MAX_AB > BOOT_CYCLES) ? MAX_AB : BOOT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] SPI_LAST  = CNT_W'(SPI_IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DET_LAST  = CNT_W'(DETACH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUIESCE,
    ST_DETACH,
    ST_BOOT,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q;
  logic             armed_q;
  logic             busy_q;
  logic             detach_q;
  logic             boot_q;
  logic             req_rise;

  // armed_q blocks the first sample after reset, so a level held through reset is not an edge
  assign req_rise = armed_q & wb_if.boot_req & ~req_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req_rise && wb_if.pll_lock) state_d = ST_QUIESCE;
      end
      ST_QUIESCE: begin
        if (!wb_if.boot_req || !wb_if.pll_lock) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (!wb_if.spi_cs) begin
          cnt_d = '0;
        end else if (cnt_q == SPI_LAST) begin
          state_d = ST_DETACH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DETACH: begin
        if (cnt_q == DET_LAST) begin
          state_d = ST_BOOT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_BOOT: begin
        if (cnt_q == BOOT_LAST) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: cnt_d = '0;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // busy tracks acceptance of the request; detach/boot lag the state by one register
  always_ff @(posedge clk_48mhz or negedge resetb) begin
    if (!resetb) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      armed_q  <= 1'b0;
      busy_q   <= 1'b0;
      detach_q <= 1'b0;
      boot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= wb_if.boot_req;
      armed_q  <= 1'b1;
      busy_q   <= (state_d != ST_IDLE);
      detach_q <= (state_q inside {ST_DETACH, ST_BOOT, ST_DONE});
      boot_q   <= (state_q inside {ST_BOOT, ST_DONE});
    end
  end

  assign wb_if.busy       = busy_q;
  assign wb_if.usb_detach = detach_q;
  assign wb_if.wb_boot    = boot_q;
  assign wb_if.wb_s       = IMAGE_SEL;

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Bench for warmboot_sequencer: vector table plus hand-written sequences, checked via a scoreboard.
module tb_warmboot_sequencer;

  logic clk    = 1'b0;
  logic resetb = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  warmboot_sequencer_if wbus ();

  warmboot_sequencer #(
    .IMAGE_SEL      (2'b01),
    .SPI_IDLE_CYCLES(4),
    .DETACH_CYCLES  (10),
    .BOOT_CYCLES    (2)
  ) dut (
    .clk_48mhz(clk),
    .resetb   (resetb),
    .wb_if    (wbus)
  );

  // expected {busy, usb_detach, wb_boot} at an absolute cycle
  typedef struct {
    string      name;
    int         at;
    logic [2:0] exp;
  } sb_t;

  typedef struct {
    string      name;
    bit         br;
    bit         pl;
    bit         cs;
    int         n;
    logic [2:0] exp;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[6];

  function automatic logic [2:0] outs();
    return {wbus.busy, wbus.usb_detach, wbus.wb_boot};
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: busy/detach/boot got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input string name, input int at, input logic [2:0] exp);
    sb.push_back('{name: name, at: at, exp: exp});
  endtask

  task automatic sample();
    sb_t e;
    checks++;
    if (wbus.wb_s !== 2'b01) begin
      failures++;
      $display("FAIL wb_s: got %b want 01 (cycle %0d)", wbus.wb_s, cyc);
    end
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at != cyc) begin
        checks++;
        failures++;
        $display("FAIL %s: stale entry for cycle %0d seen at cycle %0d", e.name, e.at, cyc);
      end else begin
        chk(e.name, outs(), e.exp);
      end
    end
  endtask

  // compare the current cycle at the falling edge, then step to just after the next rising edge
  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetb         = 1'b0;
    wbus.boot_req  = 1'b0;
    wbus.pll_lock  = 1'b1;
    wbus.spi_cs    = 1'b1;
    #1;
    chk("reset_state", outs(), 3'b000);
    repeat (2) tick();
    resetb = 1'b1;
    repeat (3) tick();
  endtask

  task automatic run_seq(input string name, input int len);
    int t;
    tick();
    t = cyc;
    for (int r = 0; r <= len; r++)
      push(name, t + r, {r >= 1, r >= 6, r >= 16});
    wbus.pll_lock = 1'b1;
    wbus.spi_cs   = 1'b1;
    wbus.boot_req = 1'b1;
    repeat (len) tick();
    tick();
  endtask

  initial begin
    int t;
    vecs[0] = '{"s4_req_nolock", 1'b1, 1'b0, 1'b1, 5,  3'b000};
    vecs[1] = '{"s4_lock_late",  1'b1, 1'b1, 1'b1, 50, 3'b000};
    vecs[2] = '{"s4_release",    1'b0, 1'b1, 1'b1, 3,  3'b000};
    vecs[3] = '{"s3_quiesce",    1'b1, 1'b1, 1'b1, 3,  3'b100};
    vecs[4] = '{"s3_abort",      1'b0, 1'b1, 1'b1, 2,  3'b000};
    vecs[5] = '{"s3_idle",       1'b0, 1'b1, 1'b1, 10, 3'b000};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      tick();
      t = cyc;
      push(vecs[i].name, t + vecs[i].n - 1, vecs[i].exp);
      wbus.boot_req = vecs[i].br;
      wbus.pll_lock = vecs[i].pl;
      wbus.spi_cs   = vecs[i].cs;
      repeat (vecs[i].n - 1) tick();
    end
    run_seq("s3_restart", 30);

    do_reset();
    run_seq("s1_nominal", 116);

    // spi_cs low every third cycle keeps QUIESCE from completing
    do_reset();
    tick();
    t = cyc;
    push("s2_start", t, 3'b000);
    for (int r = 1; r <= 19; r++) push("s2_hold", t + r, 3'b100);
    push("s2_detach", t + 20, 3'b110);
    wbus.boot_req = 1'b1;
    for (int r = 0; r < 15; r++) begin
      wbus.spi_cs = (r % 3 != 2);
      tick();
    end
    wbus.spi_cs = 1'b1;
    repeat (5) tick();
    tick();

    // inputs dropped once DETACH has started must not stop the sequence
    do_reset();
    tick();
    t = cyc;
    push("s5_detach", t + 6, 3'b110);
    wbus.boot_req = 1'b1;
    repeat (8) tick();
    wbus.boot_req = 1'b0;
    wbus.pll_lock = 1'b0;
    wbus.spi_cs   = 1'b0;
    push("s5_pre_boot", t + 15, 3'b110);
    push("s5_boot", t + 16, 3'b111);
    push("s5_done", t + 40, 3'b111);
    repeat (32) tick();
    tick();

    // asynchronous reset while wb_boot is high, boot_req held through release
    do_reset();
    tick();
    t = cyc;
    push("s6_pre_boot", t + 15, 3'b110);
    wbus.boot_req = 1'b1;
    repeat (16) tick();
    chk("s6_in_boot", outs(), 3'b111);
    resetb = 1'b0;
    #2;
    chk("s6_async_rst", outs(), 3'b000);
    repeat (2) tick();
    resetb = 1'b1;
    t = cyc;
    for (int r = 0; r <= 50; r++) push("s6_no_retrigger", t + r, 3'b000);
    repeat (50) tick();
    tick();

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
